// File: rtl/tv80_reg_arb_pkg.sv
// rtl/tv80_reg_arb_pkg.sv - shared FSM encodings, pair indices and word width for tv80_reg_arb
package tv80_reg_arb_pkg;

    localparam int WORD_W = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_STALL  = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_ACK    = 3'd3;
    localparam logic [2:0] ST_DUMP   = 3'd4;

    localparam logic [2:0] REG_BC  = 3'd0;
    localparam logic [2:0] REG_DE  = 3'd1;
    localparam logic [2:0] REG_HL  = 3'd2;
    localparam logic [2:0] REG_IX  = 3'd3;
    localparam logic [2:0] REG_BC2 = 3'd4;
    localparam logic [2:0] REG_DE2 = 3'd5;
    localparam logic [2:0] REG_HL2 = 3'd6;
    localparam logic [2:0] REG_IY  = 3'd7;

endpackage

// File: rtl/tv80_reg_arb_dump.sv
// rtl/tv80_reg_arb_dump.sv - tv80_reg_dump_seq: walks register pairs out over a valid/ready stream
module tv80_reg_dump_seq
    import tv80_reg_arb_pkg::*;
#(
    parameter int DUMP_PAIRS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              dump_ready,
    input  logic [WORD_W-1:0] rdData,
    output logic [2:0]        rdAddr,
    output logic              dump_valid,
    output logic [2:0]        dump_idx,
    output logic [WORD_W-1:0] dump_data,
    output logic              dump_done,
    output logic              lastXfer
);

    localparam logic [2:0] LAST_IDX = 3'(DUMP_PAIRS - 1);

    logic       active;
    logic [2:0] cnt;

    assign rdAddr   = cnt;
    assign lastXfer = dump_valid && dump_ready && (dump_idx == LAST_IDX);

    // One bubble cycle per word: the read address settles on cnt, then the word is captured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active     <= 1'b0;
            cnt        <= REG_BC;
            dump_valid <= 1'b0;
            dump_idx   <= REG_BC;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            dump_done <= lastXfer;
            if (start) begin
                active     <= 1'b1;
                cnt        <= REG_BC;
                dump_valid <= 1'b0;
            end else if (active) begin
                if (!dump_valid) begin
                    dump_valid <= 1'b1;
                    dump_idx   <= cnt;
                    dump_data  <= rdData;
                end else if (dump_ready) begin
                    dump_valid <= 1'b0;
                    if (lastXfer) begin
                        active <= 1'b0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tv80_reg_arb.sv
// rtl/tv80_reg_arb.sv - port-A arbiter between tv80_core, debug access and dump engine
// Dump engine present only when TV80_REG_ARB_DUMP_EN is defined.
module tv80_reg_arb
    import tv80_reg_arb_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int DUMP_PAIRS   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              core_cen,
    input  logic [2:0]        core_addra,
    input  logic [7:0]        core_dih,
    input  logic [7:0]        core_dil,
    input  logic              core_weh,
    input  logic              core_wel,
    output logic              core_stall,
    output logic              rf_cen,
    output logic [2:0]        rf_addra,
    output logic [7:0]        rf_dih,
    output logic [7:0]        rf_dil,
    output logic              rf_weh,
    output logic              rf_wel,
    input  logic [7:0]        rf_doah,
    input  logic [7:0]        rf_doal,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [2:0]        dbg_addr,
    input  logic [1:0]        dbg_wmask,
    input  logic [WORD_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [WORD_W-1:0] dbg_rdata,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [2:0]        dump_idx,
    output logic [WORD_W-1:0] dump_data,
    output logic              dump_done
);

    logic [2:0] state;
    logic [2:0] stateNext;
    logic [2:0] stallCnt;
    logic       stallDone;
    logic       dumpOp;
    logic       dumpPend;
    logic       dumpStartIn;
    logic       dumpReq;
    logic       dumpLast;
    logic [2:0] dumpAddr;

    assign stallDone = (stallCnt == 3'(STALL_CYCLES - 1));
    assign dumpReq   = dumpStartIn | dumpPend;

`ifdef TV80_REG_ARB_DUMP_EN
    logic dumpSeqStart;

    assign dumpStartIn  = dump_start;
    assign dumpSeqStart = (state == ST_STALL) && stallDone && dumpOp;

    tv80_reg_dump_seq #(
        .DUMP_PAIRS (DUMP_PAIRS)
    ) u_dump (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (dumpSeqStart),
        .dump_ready (dump_ready),
        .rdData     ({rf_doah, rf_doal}),
        .rdAddr     (dumpAddr),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_done  (dump_done),
        .lastXfer   (dumpLast)
    );
`else
    logic [4:0] unusedDump;

    assign unusedDump  = {dump_start, dump_ready, 3'(DUMP_PAIRS - 1)};
    assign dumpStartIn = 1'b0;
    assign dumpLast    = 1'b0;
    assign dumpAddr    = REG_BC;
    assign dump_valid  = 1'b0;
    assign dump_idx    = REG_BC;
    assign dump_data   = '0;
    assign dump_done   = 1'b0;
`endif

    // Debug wins over a dump request seen in the same IDLE cycle; the dump is parked in dumpPend.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:   if (dbg_req || dumpReq) stateNext = ST_STALL;
            ST_STALL:  if (stallDone) stateNext = dumpOp ? ST_DUMP : ST_ACCESS;
            ST_ACCESS: stateNext = ST_ACK;
            ST_ACK:    stateNext = ST_IDLE;
            ST_DUMP:   if (dumpLast) stateNext = ST_IDLE;
            default:   stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            stallCnt   <= 3'd0;
            dumpOp     <= 1'b0;
            dumpPend   <= 1'b0;
            core_stall <= 1'b0;
            dbg_ack    <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            state      <= stateNext;
            core_stall <= (stateNext != ST_IDLE);
            dbg_ack    <= (stateNext == ST_ACK);
            stallCnt   <= (state == ST_STALL && !stallDone) ? stallCnt + 3'd1 : 3'd0;

            if (state == ST_IDLE && stateNext == ST_STALL) begin
                dumpOp <= !dbg_req;
            end

            if (state == ST_IDLE && !dbg_req) begin
                dumpPend <= 1'b0;
            end else if (dumpStartIn && !(dumpOp && state != ST_IDLE)) begin
                dumpPend <= 1'b1;
            end

            if (state == ST_ACCESS && !dbg_we) begin
                dbg_rdata <= {rf_doah, rf_doal};
            end
        end
    end

    // Outside IDLE and ACCESS the core's enables are forced off so a stalled core cannot write.
    always_comb begin
        rf_cen   = core_cen;
        rf_addra = core_addra;
        rf_dih   = core_dih;
        rf_dil   = core_dil;
        rf_weh   = core_weh;
        rf_wel   = core_wel;
        case (state)
            ST_IDLE: begin
            end
            ST_ACCESS: begin
                rf_cen   = 1'b1;
                rf_addra = dbg_addr;
                rf_dih   = dbg_wdata[15:8];
                rf_dil   = dbg_wdata[7:0];
                rf_weh   = dbg_we & dbg_wmask[1];
                rf_wel   = dbg_we & dbg_wmask[0];
            end
            ST_DUMP: begin
                rf_cen   = 1'b0;
                rf_addra = dumpAddr;
                rf_weh   = 1'b0;
                rf_wel   = 1'b0;
            end
            default: begin
                rf_cen = 1'b0;
                rf_weh = 1'b0;
                rf_wel = 1'b0;
            end
        endcase
    end

endmodule
